key_press_classifier: RTL



---
 rtl/key_press_classifier.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/key_press_classifier.sv
// ============================================================================
// key_press_classifier
// ----------------------------------------------------------------------------
// Purpose:
//   Turns the debounced key level into gesture events. Each press gesture is
//   classified as a single click, a double click or a long press, and exactly
//   one registered, one-cycle pulse is emitted for it. Downstream logic such as
//   beep, LED or mode control can act on these pulses. It does not need to
//   decode raw levels or edges itself.
//
// Parameters:
//   CNT_W     width of the duration counter
//   CNT_LONG  hold time, in clock cycles, that qualifies a long press
//   CNT_DBL   largest release gap, in clock cycles, that still allows a
//             second press to form a double click
//   Required ordering: 2 <= CNT_DBL < CNT_LONG < 2**CNT_W
//
// Ports:
//   sys_clk       in   system clock (single clock domain)
//   sys_rst_n     in   asynchronous, active-low reset
//   key_level     in   debounced key level, 0 = pressed, 1 = released,
//                      already synchronous to sys_clk
//   single_click  out  one-cycle pulse, single click classified
//   double_click  out  one-cycle pulse, double click classified
//   long_press    out  one-cycle pulse, long press classified
//   busy          out  high while a gesture is in progress (state != IDLE)
// ============================================================================
module key_press_classifier #(
    parameter int unsigned      CNT_W    = 26,
    parameter logic [CNT_W-1:0] CNT_LONG = 26'd50_000_000,
    parameter logic [CNT_W-1:0] CNT_DBL  = 26'd15_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_level,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    // Terminal counts. The counter is 0 in the edge that enters a timed
    // state. So a terminal count of N-1 fires on the N-th edge after entry.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_LONG - 1'b1;
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_DBL  - 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HOLD
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_single;
    logic             r_double;
    logic             r_long;
    logic             r_busy;

    logic             w_pressed;
    logic             w_long_hit;
    logic             w_dbl_hit;

    assign w_pressed  = ~key_level;
    assign w_long_hit = (r_cnt == LONG_LAST);
    assign w_dbl_hit  = (r_cnt == DBL_LAST);

    // Within each timed state, the key-level test comes before the timeout
    // test. When a key change and a timeout fall on the same edge, the key
    // change wins. This handles a press at the last gap cycle and a release
    // at the last hold cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_pressed) begin
                        r_state <= PRESS1;
                        r_busy  <= 1'b1;
                    end
                end

                PRESS1: begin
                    if (!w_pressed) begin
                        r_state <= WAIT2;
                        r_cnt   <= '0;
                    end else if (w_long_hit) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                        r_long  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end

                WAIT2: begin
                    if (w_pressed) begin
                        r_state  <= PRESS2;
                        r_cnt    <= '0;
                    end else if (w_dbl_hit) begin
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                        r_single <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end

                PRESS2: begin
                    if (!w_pressed) begin
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                        r_double <= 1'b1;
                        r_busy   <= 1'b0;
                    end else if (w_long_hit) begin
                        // The second press was held too long, so it becomes a
                        // long press. The pending double click is dropped.
                        r_state  <= HOLD;
                        r_cnt    <= '0;
                        r_long   <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end

                HOLD: begin
                    // The long press was already reported. Wait silently for
                    // the release.
                    r_cnt <= '0;
                    if (!w_pressed) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign single_click = r_single;
    assign double_click = r_double;
    assign long_press   = r_long;
    assign busy         = r_busy;

endmodule
